// File: rtl/cla_mod_counter.sv
// Modulo-MODULO up/down counter whose next count comes from a GROUP-bit carry-lookahead incrementer/decrementer.
// Optional macro SATURATE_EN: hold at the range limits instead of wrapping (wrap stays 0).
module cla_mod_counter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned MODULO = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam int unsigned      NGRP    = (WIDTH + GROUP - 1) / GROUP;
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [NGRP-1:0]  gc_c;
    logic [WIDTH-1:0] cin_c;
    logic             acc_c;
    logic             load_over_c;

    // Lookahead: a bit "propagates" when it is 1 counting up or 0 counting down.
    // Group carries chain through group-propagate terms; each bit then ANDs its
    // group carry with the in-group prefix, so there is no bit-serial ripple.
    always_comb begin
        gc_c    = '0;
        cin_c   = '0;
        acc_c   = 1'b0;
        gc_c[0] = 1'b1;
        for (int unsigned g = 1; g < NGRP; g++) begin
            acc_c = gc_c[g-1];
            for (int unsigned j = (g - 1) * GROUP; j < g * GROUP; j++) begin
                acc_c = acc_c & (count_q[j] ~^ up);
            end
            gc_c[g] = acc_c;
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            acc_c = gc_c[i / GROUP];
            for (int unsigned j = (i / GROUP) * GROUP; j < i; j++) begin
                acc_c = acc_c & (count_q[j] ~^ up);
            end
            cin_c[i] = acc_c;
        end
    end

    assign tc          = up ? (count_q == MAX_CNT) : (count_q == '0);
    assign load_over_c = ({1'b0, load_val} >= MOD_EXT);

    // Next-state: clr > load > en; at the range limit the lookahead result is replaced.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_over_c ? MAX_CNT : load_val;
        end else if (en) begin
            if (tc) begin
`ifdef SATURATE_EN
                count_d = count_q;
`else
                count_d = up ? '0 : MAX_CNT;
                wrap_d  = 1'b1;
`endif
            end else begin
                count_d = count_q ^ cin_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_cla_mod_counter.sv
// Self-checking bench for cla_mod_counter: four parameterisations share one stimulus stream
// and are compared every cycle against an arithmetic model, plus hand-computed literal checks.
module tb_cla_mod_counter;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int unsigned MODS [4] = '{256, 10, 100, 1000};
    localparam int unsigned WIDS [4] = '{8, 8, 8, 10};

    logic       clk;
    logic       rst, clr, load, en, up;
    logic [9:0] lv;

    logic [7:0] cnt_def, cnt_m10, cnt_m100;
    logic [9:0] cnt_w10;
    logic       tc_def, tc_m10, tc_m100, tc_w10;
    logic       wr_def, wr_m10, wr_m100, wr_w10;

    logic [9:0] dut_cnt  [4];
    logic       dut_tc   [4];
    logic       dut_wrap [4];

    int unsigned m_cnt  [4];
    bit          m_wrap [4];
    bit          m_valid;
    int unsigned ld_v;

    int n_vec;
    int n_miss;

    cla_mod_counter #(.WIDTH(8), .GROUP(4), .MODULO(256)) u_def (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[7:0]),
        .en(en), .up(up), .count(cnt_def), .tc(tc_def), .wrap(wr_def));
    cla_mod_counter #(.WIDTH(8), .GROUP(4), .MODULO(10)) u_m10 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[7:0]),
        .en(en), .up(up), .count(cnt_m10), .tc(tc_m10), .wrap(wr_m10));
    cla_mod_counter #(.WIDTH(8), .GROUP(4), .MODULO(100)) u_m100 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv[7:0]),
        .en(en), .up(up), .count(cnt_m100), .tc(tc_m100), .wrap(wr_m100));
    cla_mod_counter #(.WIDTH(10), .GROUP(3), .MODULO(1000)) u_w10 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(lv),
        .en(en), .up(up), .count(cnt_w10), .tc(tc_w10), .wrap(wr_w10));

    assign dut_cnt[0] = {2'b00, cnt_def};
    assign dut_cnt[1] = {2'b00, cnt_m10};
    assign dut_cnt[2] = {2'b00, cnt_m100};
    assign dut_cnt[3] = cnt_w10;
    assign dut_tc[0] = tc_def;
    assign dut_tc[1] = tc_m10;
    assign dut_tc[2] = tc_m100;
    assign dut_tc[3] = tc_w10;
    assign dut_wrap[0] = wr_def;
    assign dut_wrap[1] = wr_m10;
    assign dut_wrap[2] = wr_m100;
    assign dut_wrap[3] = wr_w10;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: plain modular arithmetic on integers.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_cnt[k]  = 0;
                m_wrap[k] = 1'b0;
            end else if (clr) begin
                m_cnt[k]  = 0;
                m_wrap[k] = 1'b0;
            end else if (load) begin
                ld_v      = 32'(lv) % (32'd1 << WIDS[k]);
                m_cnt[k]  = (ld_v >= MODS[k]) ? MODS[k] - 1 : ld_v;
                m_wrap[k] = 1'b0;
            end else if (en && up) begin
                if (m_cnt[k] == MODS[k] - 1) begin
                    m_cnt[k]  = SAT ? MODS[k] - 1 : 0;
                    m_wrap[k] = !SAT;
                end else begin
                    m_cnt[k]  = m_cnt[k] + 1;
                    m_wrap[k] = 1'b0;
                end
            end else if (en) begin
                if (m_cnt[k] == 0) begin
                    m_cnt[k]  = SAT ? 0 : MODS[k] - 1;
                    m_wrap[k] = !SAT;
                end else begin
                    m_cnt[k]  = m_cnt[k] - 1;
                    m_wrap[k] = 1'b0;
                end
            end else begin
                m_wrap[k] = 1'b0;
            end
        end
        if (rst) m_valid = 1'b1;
    end

    // Every-cycle comparison, sampled 2 time units after the rising edge.
    always @(posedge clk) begin
        #2;
        if (m_valid) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("model count[%0d]", k), 32'(dut_cnt[k]), m_cnt[k]);
                check($sformatf("model wrap[%0d]", k), 32'(dut_wrap[k]), 32'(m_wrap[k]));
                check($sformatf("model tc[%0d]", k), 32'(dut_tc[k]),
                      32'(up ? (m_cnt[k] == MODS[k] - 1) : (m_cnt[k] == 0)));
            end
        end
    end

    task automatic tick(input bit r, input bit c, input bit l, input int unsigned v,
                        input bit e, input bit u);
        @(negedge clk);
        rst  = r;
        clr  = c;
        load = l;
        lv   = 10'(v);
        en   = e;
        up   = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        m_valid = 1'b0;
        rst = 1'b1; clr = 1'b0; load = 1'b0; lv = '0; en = 1'b0; up = 1'b0;

        // reset dominates load and en
        tick(1, 0, 1, 77, 1, 0);
        check("rst count", 32'(cnt_def), 0);
        check("rst wrap", 32'(wr_def), 0);
        check("rst tc down", 32'(tc_def), 1);
        check("rst count m10", 32'(cnt_m10), 0);
        for (int n = 0; n < 5; n++) tick(0, 0, 0, 0, 1, 1);
        check("count after 5", 32'(cnt_def), 5);
        check("count after 5 w10", 32'(cnt_w10), 5);
        check("tc mid up", 32'(tc_def), 0);

        // MODULO=10 up wrap
        tick(0, 0, 1, 9, 1, 1);
        check("m10 load 9", 32'(cnt_m10), 9);
        check("m10 tc at 9", 32'(tc_m10), 1);
        tick(0, 0, 0, 0, 1, 1);
        check("m10 wrap count", 32'(cnt_m10), SAT ? 9 : 0);
        check("m10 wrap pulse", 32'(wr_m10), SAT ? 0 : 1);
        check("def 9->10", 32'(cnt_def), 10);
        tick(0, 0, 0, 0, 0, 1);
        check("m10 wrap one cycle", 32'(wr_m10), 0);

        // down wrap from 0
        tick(0, 1, 0, 0, 1, 1);
        check("clr", 32'(cnt_m100), 0);
        tick(0, 0, 0, 0, 1, 0);
        check("m10 down wrap", 32'(cnt_m10), SAT ? 0 : 9);
        check("m10 down wrap pulse", 32'(wr_m10), SAT ? 0 : 1);
        check("def down wrap", 32'(cnt_def), SAT ? 0 : 255);
        check("m100 down wrap", 32'(cnt_m100), SAT ? 0 : 99);
        check("w10 down wrap", 32'(cnt_w10), SAT ? 0 : 999);

        // load clamp and clr over load
        tick(0, 0, 1, 200, 1, 1);
        check("m100 clamp", 32'(cnt_m100), 99);
        check("def load 200", 32'(cnt_def), 200);
        check("m10 clamp", 32'(cnt_m10), 9);
        check("w10 load 200", 32'(cnt_w10), 200);
        tick(0, 1, 1, 50, 1, 1);
        check("clr beats load", 32'(cnt_m100), 0);

        // cross-group carries
        tick(0, 0, 1, 15, 0, 1);
        tick(0, 0, 0, 0, 1, 1);
        check("def 0F->10", 32'(cnt_def), 16);
        tick(0, 0, 1, 255, 0, 1);
        tick(0, 0, 0, 0, 1, 1);
        check("def FF->00", 32'(cnt_def), SAT ? 255 : 0);
        check("def FF wrap", 32'(wr_def), SAT ? 0 : 1);
        check("m100 99->0", 32'(cnt_m100), SAT ? 99 : 0);
        tick(0, 0, 1, 511, 0, 1);
        tick(0, 0, 0, 0, 1, 1);
        check("w10 1FF->200", 32'(cnt_w10), 512);
        tick(0, 0, 0, 0, 1, 0);
        check("w10 200->1FF", 32'(cnt_w10), 511);
        tick(0, 0, 1, 64, 0, 0);
        tick(0, 0, 0, 0, 1, 0);
        check("def 40->3F", 32'(cnt_def), 63);

        // held at top for three edges
        tick(0, 0, 1, 255, 0, 1);
        for (int n = 0; n < 3; n++) tick(0, 0, 0, 0, 1, 1);
        check("def 255 x3", 32'(cnt_def), SAT ? 255 : 2);
        check("def 255 x3 wrap", 32'(wr_def), 0);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 0);
        check("def down at 0", 32'(cnt_def), SAT ? 0 : 255);

        // reset mid-count
        tick(0, 0, 1, 123, 0, 1);
        tick(1, 1, 1, 77, 1, 1);
        check("rst mid count", 32'(cnt_def), 0);
        check("rst mid w10", 32'(cnt_w10), 0);

        // random stretch checked by the model
        for (int n = 0; n < 400; n++) begin
            tick($urandom_range(63) == 0, $urandom_range(31) == 0, $urandom_range(15) == 0,
                 $urandom_range(1023), $urandom_range(3) != 0, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #100000;
        n_miss++;
        $display("FAIL watchdog: simulation time limit reached, expected end of stimulus");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
